// File: rtl/snitch_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snitch_mem_pkg
// Description : Shared types, default widths and helpers for the Snitch
//               memory arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package snitch_mem_pkg;

    localparam int unsigned DefaultNumReq         = 2;
    localparam int unsigned DefaultAddrWidth      = 10;
    localparam int unsigned DefaultDataWidth      = 32;
    localparam int unsigned DefaultMaxOutstanding = 2;

    typedef struct packed {
        logic [DefaultAddrWidth-1:0] addr;
        logic [DefaultDataWidth-1:0] data;
        logic                        write;
        logic                        wstrb;
    } mem_req_t;

    typedef struct packed {
        logic [DefaultDataWidth-1:0] data;
    } mem_rsp_t;

    // Increment an index and wrap it back to zero at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snitch_id_fifo.sv
`default_nettype none
// ============================================================================
// Module      : snitch_id_fifo
// Description : Small synchronous FIFO holding requester IDs of reads that
//               are in flight, in issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module snitch_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_push_ok;
    logic               w_pop_ok;

    assign o_full    = (r_cnt == c_FULL);
    assign o_empty   = (r_cnt == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    // Storage write; contents need no reset since the count qualifies them.
    always_ff @(posedge clk_i) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap at DEPTH; count tracks occupancy across push/pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snitch_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snitch_mem_arbiter
// Description : Round-robin arbiter sharing one single-port memory between
//               several Snitch requesters; read responses are routed back
//               through an in-order ID FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module snitch_mem_arbiter
    import snitch_mem_pkg::*;
#(
    parameter int unsigned NumReq         = DefaultNumReq,
    parameter int unsigned AddrWidth      = DefaultAddrWidth,
    parameter int unsigned DataWidth      = DefaultDataWidth,
    parameter int unsigned MaxOutstanding = DefaultMaxOutstanding
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    input  logic [NumReq-1:0]           req_write_i,
    input  logic [NumReq-1:0]           req_wstrb_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic [NumReq*DataWidth-1:0] rsp_data_o,
    output logic [NumReq-1:0]           rsp_valid_o,
    input  logic [NumReq-1:0]           rsp_ready_i,
    output logic [AddrWidth-1:0]        mem_req_addr_o,
    output logic [DataWidth-1:0]        mem_req_data_o,
    output logic                        mem_req_write_o,
    output logic                        mem_req_wstrb_o,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    input  logic [DataWidth-1:0]        mem_rsp_data_i,
    input  logic                        mem_rsp_valid_i,
    output logic                        mem_rsp_ready_o,
    output logic                        err_o
);

    localparam int unsigned c_ID_W = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [c_ID_W-1:0] r_rr;
    logic              r_lock;
    logic [c_ID_W-1:0] r_lock_id;
    logic              r_err;
    logic [NumReq-1:0] w_elig;
    logic [c_ID_W-1:0] w_gnt;
    logic              w_gnt_valid;
    logic              w_hs;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [c_ID_W-1:0] w_head;

    // A full FIFO blocks reads outright, even if a response pops this cycle.
    assign w_elig      = req_valid_i & (req_write_i | {NumReq{!w_full}});
    assign w_gnt_valid = r_lock || (|w_elig);
    assign w_hs        = w_gnt_valid && mem_req_ready_i;
    assign w_push      = w_hs && !req_write_i[w_gnt];
    assign err_o       = r_err;

    // Pick the first eligible requester at or after the pointer; a stalled grant wins.
    always_comb begin
        int unsigned idx;
        logic        found;
        w_gnt = r_rr;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx = 32'(r_rr) + k;
            if (idx >= NumReq) begin
                idx = idx - NumReq;
            end
            if (!found && w_elig[idx]) begin
                w_gnt = c_ID_W'(idx);
                found = 1'b1;
            end
        end
        if (r_lock) begin
            w_gnt = r_lock_id;
        end
    end

    // Forward the granted requester's fields and return the memory's ready to it.
    always_comb begin
        mem_req_addr_o  = req_addr_i[w_gnt*AddrWidth +: AddrWidth];
        mem_req_data_o  = req_data_i[w_gnt*DataWidth +: DataWidth];
        mem_req_write_o = req_write_i[w_gnt];
        mem_req_wstrb_o = req_wstrb_i[w_gnt];
        mem_req_valid_o = w_gnt_valid;
        req_ready_o     = '0;
        if (w_gnt_valid) begin
            req_ready_o[w_gnt] = mem_req_ready_i;
        end
    end

    // Route the memory response to the oldest outstanding reader; drop beats with no owner.
    always_comb begin
        rsp_valid_o     = '0;
        rsp_data_o      = '0;
        mem_rsp_ready_o = mem_rsp_valid_i;
        if (!w_empty) begin
            rsp_valid_o[w_head]                    = mem_rsp_valid_i;
            rsp_data_o[w_head*DataWidth +: DataWidth] = mem_rsp_data_i;
            mem_rsp_ready_o                        = rsp_ready_i[w_head];
        end
    end

    assign w_pop = mem_rsp_valid_i && mem_rsp_ready_o && !w_empty;

    // Round-robin pointer advances past the winner; a stalled request holds the grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr      <= '0;
            r_lock    <= 1'b0;
            r_lock_id <= '0;
        end else if (w_hs) begin
            r_rr   <= c_ID_W'(wrap_inc(32'(w_gnt), NumReq));
            r_lock <= 1'b0;
        end else if (w_gnt_valid) begin
            r_lock    <= 1'b1;
            r_lock_id <= w_gnt;
        end
    end

    // Sticky flag for a response beat arriving with no read outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (mem_rsp_valid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

    snitch_id_fifo #(
        .WIDTH (c_ID_W),
        .DEPTH (MaxOutstanding)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_push  (w_push),
        .i_data  (w_gnt),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

endmodule
`default_nettype wire
